// File: rtl/fast_counter_pkg.sv
// rtl/fast_counter_pkg.sv - shared types and sizing helpers for the carry-select counter
package fast_counter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    // Number of slices needed to cover width bits (ceiling division)
    function automatic int num_groups(input int width, input int group);
        return (width + group - 1) / group;
    endfunction

    // Width of slice k; only the top slice can be narrower than group
    function automatic int group_width(input int width, input int group, input int k);
        return ((k + 1) * group > width) ? (width - k * group) : group;
    endfunction

endpackage

// File: rtl/fast_counter_incdec_group.sv
// rtl/fast_counter_incdec_group.sv - one carry-select slice: local +/-1 and boundary flags
module incdec_group #(
    parameter int W = 3
) (
    input  logic [W-1:0] in,
    input  logic         up,
    output logic [W-1:0] out,
    output logic         all1,
    output logic         all0
);

    // Local step is independent of lower slices; the top level decides whether to use it
    assign out  = up ? (in + W'(1)) : (in - W'(1));
    assign all1 = &in;
    assign all0 = ~|in;

endmodule

// File: rtl/fast_counter.sv
// rtl/fast_counter.sv - parametrised up/down counter with carry-select slice incrementor
module fast_counter
    import fast_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int GROUP    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             all1,
    output logic             all0,
    output logic             wrap,
    output logic             sat
);

    localparam int NG = num_groups(WIDTH, GROUP);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] stepped;
    logic             wrap_q;
    logic             wrap_nxt;
    logic             sat_q;
    logic             sat_nxt;
    logic [NG-1:0]    g_all1;
    logic [NG-1:0]    g_all0;
    logic [NG-1:0]    g_flag;
    logic [NG-1:0]    g_sel;
    logic             carry_out;
    logic             up;
    op_e              op;

    // Decode the per-cycle operation in priority order (rst is handled in the register)
    always_comb begin
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (ld) begin
            op = OP_LOAD;
        end else if (inc && !dec) begin
            op = OP_INC;
        end else if (dec && !inc) begin
            op = OP_DEC;
        end
    end

    assign up = (op != OP_DEC);

    // Each slice steps only when every lower slice sits at the boundary for this direction
    for (genvar k = 0; k < NG; k++) begin : g_slice
        localparam int LO = k * GROUP;
        localparam int GW = group_width(WIDTH, GROUP, k);

        logic [GW-1:0] slice_out;

        incdec_group #(.W(GW)) u_grp (
            .in   (cnt_q[LO +: GW]),
            .up   (up),
            .out  (slice_out),
            .all1 (g_all1[k]),
            .all0 (g_all0[k])
        );

        assign g_flag[k] = up ? g_all1[k] : g_all0[k];

        if (k == 0) begin : g_sel_first
            assign g_sel[k] = 1'b1;
        end else begin : g_sel_upper
            assign g_sel[k] = &g_flag[k-1:0];
        end

        assign stepped[LO +: GW] = g_sel[k] ? slice_out : cnt_q[LO +: GW];
    end

    assign carry_out = &g_flag;

    // Next count and flags; a blocked step in saturate mode leaves the count untouched
    always_comb begin
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        sat_nxt  = sat_q;
        case (op)
            OP_CLR: begin
                cnt_nxt = '0;
                sat_nxt = 1'b0;
            end
            OP_LOAD: begin
                cnt_nxt = ld_val;
                sat_nxt = 1'b0;
            end
            OP_INC, OP_DEC: begin
                if (carry_out && (SATURATE != 0)) begin
                    sat_nxt = 1'b1;
                end else begin
                    cnt_nxt  = stepped;
                    wrap_nxt = carry_out;
                end
            end
            default: ;
        endcase
    end

    // Count, wrap pulse and sticky saturate flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
            sat_q  <= sat_nxt;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;
    assign all1 = &cnt_q;
    assign all0 = ~|cnt_q;

endmodule

// File: doc/fast_counter.md
# fast_counter

Parametrised up/down counter built on a carry-select group incrementor, the next generation of the fixed 9-bit fast incrementor. The count register is split into GROUP-bit slices, each with its own local increment/decrement. Group all-ones/all-zeros flags select each slice's new value, so the critical path is one group plus a flag AND-chain rather than a full ripple. It sits in the CPU as the building block for the PC-sequential path, loop and event counters, and timer prescalers.

## Interface
- WIDTH, 32: counter width in bits, legal range ≥2.
- GROUP, 3: carry-select slice width, legal range 1..WIDTH. If WIDTH % GROUP ≠ 0, the top slice is narrower.
- SATURATE, 0: 0 = wrap at the limits; 1 = clamp at the limits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous clear of the count to 0.
- ld  in  1  load ld_val.
- ld_val  in  WIDTH  load value.
- inc  in  1  count up by 1.
- dec  in  1  count down by 1.
- cnt  out  WIDTH  registered count.
- all1  out  1  cnt == all-ones; decoded from the register only.
- all0  out  1  cnt == 0; decoded from the register only.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- sat  out  1  sticky flag: a count was blocked at a limit (SATURATE=1 only).

## Operation
- Priority per cycle: rst > clr > ld > (inc XOR dec) > hold.
- inc & dec together is a hold. It produces no wrap and no sat.
- rst: cnt=0, wrap=0, sat=0.
- clr: cnt=0, wrap=0, sat=0.
- ld: cnt=ld_val, wrap=0, sat=0. ld_val is taken as-is with no range check.
- Up-count, per slice k:
  - Slice 0 always takes its local increment.
  - Slice k>0 takes its local increment only when every lower slice is all-ones. Otherwise it holds.
- Down-count uses the same scheme with all-zeros flags and local decrement.
- The carry-out is the AND of all slice flags.
- Up-count from all-ones:
  - SATURATE=0: cnt→0 and wrap=1 for the next cycle.
  - SATURATE=1: cnt holds all-ones, wrap stays 0, and sat is set.
- Down-count from 0:
  - SATURATE=0: cnt→all-ones and wrap=1.
  - SATURATE=1: cnt holds 0 and sat is set.
- wrap is 0 in every cycle that did not wrap; it never stretches.
- sat stays set until rst, clr or ld.
- Arithmetic is modulo 2^WIDTH in wrap mode. There is no signed interpretation.

## Timing
- cnt, wrap and sat are registered; their reset value is 0.
- Latency: a control input sampled at edge N is visible on cnt, wrap and sat after edge N.
- all1 and all0 are combinational from cnt only, so they are valid in the same cycle as cnt. Their reset values are all1=0 and all0=1.
- No combinational path exists from any input to any output.
- Back-to-back operations sustain one per cycle with no bubbles.
- Reset mid-operation: rst in any cycle overrides everything. Flags clear after that edge, and any wrap pulse due for the next cycle is suppressed.
- clr or ld asserted in the same cycle as a wrapping inc suppresses that wrap.
- The critical path is one slice increment plus a ceil(WIDTH/GROUP)-input AND and a 2:1 mux. No tree is needed at the default width.

## Structure
- fast_counter_pkg holds:
  - op_e enum {OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC}, the decoded per-cycle operation;
  - function num_groups(WIDTH, GROUP) = ceil division;
  - function group_width(k) for the narrow top slice.
- Sub-module incdec_group (parameter W):
  - ports: in[W], up, out[W], all1, all0;
  - purely combinational; instantiated once per slice in a generate loop.
- The top level holds the op decode, the slice-select chain, the count register, and the wrap/sat registers.

## Test plan
- Reset, then inc held high, WIDTH=9, GROUP=3, SATURATE=0: cnt 0,1,2…511 then 0. wrap=1 exactly in the cycle cnt reads 0 after 511; all1=1 only at 511.
- Slice-boundary carry: ld 0x0FF with WIDTH=9, GROUP=3 → 0x0FF; then inc → 0x100. Next, ld 0x1C7 → 0x1C7; then inc → 0x1C8. Finally dec from 0x040 → 0x03F.
- Down-wrap, WIDTH=8, GROUP=3: ld 0 then dec → cnt=0xFF, wrap=1 for exactly one cycle, all0 falls.
- Saturate, SATURATE=1, WIDTH=8: ld 0xFF then inc ×3 → cnt stays 0xFF, wrap=0, sat=1 and sticky. ld 0x10 → sat=0 and cnt=0x10.
- Priority and simultaneity:
  - inc=dec=1 from 0x55 → holds 0x55;
  - clr=ld=inc=1 → cnt=0;
  - ld=inc=1, ld_val=0x20 → 0x20.
- Mid-operation reset: inc at all-ones with rst=1 in the same cycle → cnt=0, wrap=0, sat=0.
- Randomised ops across (WIDTH, GROUP) ∈ {(9,3), (32,3), (32,4), (7,7), (5,1)} are checked against a behavioural ±1 model.
